// File: rtl/bit_packer_fifo.sv
// Serial bit-to-byte packer (MSB first) feeding a circular byte FIFO with a registered read port.
// Optional BIT_PACKER_DCOUNT_EN adds dcount_out, a saturating count of buffered bits.
module bit_packer_fifo #(
    parameter int unsigned DEPTH   = 2048,
    parameter logic        PAD_BIT = 1'b0
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        din,
    input  logic        wr_en,
    input  logic        flush,
    input  logic        rd_en,
    output logic [7:0]  dout,
    output logic        d_valid_out,
    output logic        full,
    output logic        empty,
    output logic        overflow
`ifdef BIT_PACKER_DCOUNT_EN
    ,
    output logic [15:0] dcount_out
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    pack_reg;
    logic [2:0]    bit_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [7:0]    mem [DEPTH];

    logic [7:0]    shifted;
    logic [2:0]    n;
    logic          byte_done;
    logic          flush_push;
    logic          push;
    logic [3:0]    pad_sh;
    logic [7:0]    push_byte;
    logic          can_push;
    logic          do_push;
    logic          do_read;
    logic [CW-1:0] count_nxt;
    logic [7:0]    pack_nxt;
    logic [2:0]    bit_cnt_nxt;

    always_comb begin
        shifted    = wr_en ? {pack_reg[6:0], din} : pack_reg;
        n          = wr_en ? bit_cnt + 3'd1 : bit_cnt;
        byte_done  = wr_en && (bit_cnt == 3'd7);
        // flush sees the post-write bit count, so a just-completed byte is never padded twice
        flush_push = flush && (n != 3'd0);
        push       = byte_done || flush_push;
        pad_sh     = 4'd8 - {1'b0, n};
        if (byte_done)
            push_byte = shifted;
        else
            push_byte = (shifted << pad_sh) | ({8{PAD_BIT}} & ~(8'hFF << pad_sh));

        can_push = (fifo_count != CW'(DEPTH));
        do_push  = push && can_push;
        do_read  = rd_en && (fifo_count != '0);

        count_nxt = fifo_count;
        case ({do_push, do_read})
            2'b10:   count_nxt = fifo_count + 1'b1;
            2'b01:   count_nxt = fifo_count - 1'b1;
            default: count_nxt = fifo_count;
        endcase

        pack_nxt    = pack_reg;
        bit_cnt_nxt = bit_cnt;
        if (flush_push) begin
            pack_nxt    = '0;
            bit_cnt_nxt = '0;
        end else if (wr_en) begin
            pack_nxt    = shifted;
            bit_cnt_nxt = n;
        end
    end

    always_ff @(posedge clk) begin
        if (!srst && do_push)
            mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pack_reg    <= '0;
            bit_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            dout        <= '0;
            d_valid_out <= 1'b0;
            overflow    <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
        end else begin
            pack_reg   <= pack_nxt;
            bit_cnt    <= bit_cnt_nxt;
            fifo_count <= count_nxt;
            full       <= (count_nxt == CW'(DEPTH));
            empty      <= (count_nxt == '0);
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (push && !can_push)
                overflow <= 1'b1;
            if (do_read) begin
                dout        <= mem[rd_ptr];
                d_valid_out <= 1'b1;
                rd_ptr      <= rd_ptr + 1'b1;
            end else begin
                dout        <= '0;
                d_valid_out <= 1'b0;
            end
        end
    end

`ifdef BIT_PACKER_DCOUNT_EN
    logic [31:0] dsum;
    assign dsum = 32'(count_nxt) * 32'd8 + 32'(bit_cnt_nxt);

    always_ff @(posedge clk) begin
        if (srst)
            dcount_out <= '0;
        else
            dcount_out <= (dsum > 32'h0000_FFFF) ? 16'hFFFF : dsum[15:0];
    end
`endif

endmodule
